// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem_addr from the PC and assembles one- or two-word instructions (opcode + immediate).
// Single-word instructions appear one cycle after their address; two-word after two. Stall freezes everything; branch overrides stall.
module fetch_stage #(
  parameter int                ADDR_W       = 16,
  parameter int                INST_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] instruction,
  output logic [INST_W-1:0] immediate,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid
);

  typedef enum logic {
    FETCH = 1'b0,
    IMM   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [ADDR_W-1:0] w_pc_out_nxt;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] w_inst_nxt;
  logic [INST_W-1:0] r_imm;
  logic [INST_W-1:0] w_imm_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              w_two_word;

  assign w_two_word = (imem_data[INST_W-1 -: 3] == 3'b110);
  assign w_pc_inc   = r_pc + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In IMM the word is always taken as immediate data, even if it looks like a two-word opcode.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pc_out_nxt = r_pc_out;
    w_inst_nxt   = r_inst;
    w_imm_nxt    = r_imm;
    w_valid_nxt  = r_valid;
    if (branch) begin
      w_state_nxt = FETCH;
      w_pc_nxt    = branch_addr;
      w_inst_nxt  = '0;
      w_imm_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else if (!stall) begin
      w_pc_nxt = w_pc_inc;
      unique case (r_state)
        FETCH: begin
          w_inst_nxt   = imem_data;
          w_imm_nxt    = '0;
          w_pc_out_nxt = r_pc;
          if (w_two_word) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IMM;
          end else begin
            w_valid_nxt = 1'b1;
          end
        end
        IMM: begin
          w_imm_nxt   = imem_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = FETCH;
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RESET_VECTOR;
      r_pc_out <= '0;
      r_inst   <= '0;
      r_imm    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_inst   <= w_inst_nxt;
      r_imm    <= w_imm_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign instruction = r_inst;
  assign immediate   = r_imm;
  assign pc_out      = r_pc_out;
  assign valid       = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations against a flat instruction memory.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [15:0] branch_addr;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic [15:0] pc_out;
  logic        valid;

  logic [15:0] mem [0:65535];
  int          errors;
  int          checks;

  assign imem_data = mem[imem_addr];

  fetch_stage #(
    .ADDR_W      (16),
    .INST_W      (16),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branch     (branch),
    .branch_addr(branch_addr),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instruction(instruction),
    .immediate  (immediate),
    .pc_out     (pc_out),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every output at once; v is the expected valid bit.
  task automatic chk_all(input string tag, input logic [15:0] addr, input logic [15:0] ins,
                         input logic [15:0] imm, input logic [15:0] pco, input logic v);
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".instruction"}, instruction, ins);
    chk({tag, ".immediate"}, immediate, imm);
    chk({tag, ".pc_out"}, pc_out, pco);
    chk({tag, ".valid"}, {15'd0, valid}, {15'd0, v});
  endtask

  task automatic do_branch(input logic [15:0] target);
    branch      = 1'b1;
    branch_addr = target;
    tick();
    branch      = 1'b0;
    branch_addr = 16'h0000;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b0;
    stall       = 1'b0;
    branch      = 1'b0;
    branch_addr = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0]      = 16'h1234;
    mem[1]      = 16'h2345;
    mem[2]      = 16'h0002;
    mem[3]      = 16'h0003;
    mem[4]      = 16'hC200;
    mem[5]      = 16'h00AB;
    mem[6]      = 16'hC300;
    mem[7]      = 16'h0777;
    mem[8]      = 16'h0888;
    mem[16'h20] = 16'h2020;
    mem[16'h30] = 16'hC001;
    mem[16'h31] = 16'hC002;
    mem[16'h32] = 16'h0033;
    mem[16'h40] = 16'h1111;
    mem[16'hFFFF] = 16'h0F0F;

    // Reset held for two edges
    tick();
    tick();
    chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    reset = 1'b1;
    tick();
    chk_all("sw0", 16'h0001, 16'h1234, 16'h0000, 16'h0000, 1'b1);
    tick();
    chk_all("sw1", 16'h0002, 16'h2345, 16'h0000, 16'h0001, 1'b1);
    tick();
    tick();
    chk_all("sw3", 16'h0004, 16'h0003, 16'h0000, 16'h0003, 1'b1);

    // Two-word at 4
    tick();
    chk_all("tw_op", 16'h0005, 16'hC200, 16'h0000, 16'h0004, 1'b0);
    tick();
    chk_all("tw_imm", 16'h0006, 16'hC200, 16'h00AB, 16'h0004, 1'b1);

    // Branch while in IMM discards the opcode at 6
    tick();
    chk_all("br_op", 16'h0007, 16'hC300, 16'h0000, 16'h0006, 1'b0);
    do_branch(16'h0040);
    chk_all("br_imm", 16'h0040, 16'h0000, 16'h0000, 16'h0006, 1'b0);
    tick();
    chk_all("br_tgt", 16'h0041, 16'h1111, 16'h0000, 16'h0040, 1'b1);

    // Stall for three cycles with pc at 8
    do_branch(16'h0007);
    tick();
    chk_all("pre_stall", 16'h0008, 16'h0777, 16'h0000, 16'h0007, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("stall", 16'h0008, 16'h0777, 16'h0000, 16'h0007, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk_all("unstall", 16'h0009, 16'h0888, 16'h0000, 16'h0008, 1'b1);

    // Branch wins over simultaneous stall
    stall = 1'b1;
    do_branch(16'h0020);
    stall = 1'b0;
    chk_all("br_stall", 16'h0020, 16'h0000, 16'h0000, 16'h0008, 1'b0);
    tick();
    chk_all("br_stall_tgt", 16'h0021, 16'h2020, 16'h0000, 16'h0020, 1'b1);

    // PC wrap with a single-word instruction
    do_branch(16'hFFFF);
    tick();
    chk_all("wrap_sw", 16'h0000, 16'h0F0F, 16'h0000, 16'hFFFF, 1'b1);

    // Two-word opcode at FFFF takes its immediate from address 0
    mem[16'hFFFF] = 16'hC0DE;
    do_branch(16'hFFFF);
    tick();
    chk_all("wrap_op", 16'h0000, 16'hC0DE, 16'h0000, 16'hFFFF, 1'b0);
    tick();
    chk_all("wrap_imm", 16'h0001, 16'hC0DE, 16'h1234, 16'hFFFF, 1'b1);

    // Immediate word that looks like a two-word opcode is still data
    do_branch(16'h0030);
    tick();
    chk_all("opimm_op", 16'h0031, 16'hC001, 16'h0000, 16'h0030, 1'b0);
    tick();
    chk_all("opimm_imm", 16'h0032, 16'hC001, 16'hC002, 16'h0030, 1'b1);
    tick();
    chk_all("opimm_next", 16'h0033, 16'h0033, 16'h0000, 16'h0032, 1'b1);

    // Stall in IMM holds, then reset under stall abandons it
    do_branch(16'h0030);
    tick();
    stall = 1'b1;
    tick();
    chk_all("imm_stall", 16'h0031, 16'hC001, 16'h0000, 16'h0030, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("rst_mid", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b1;
    stall = 1'b0;
    tick();
    chk_all("rst_resume", 16'h0001, 16'h1234, 16'h0000, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
